// File: rtl/bf16_dot_acc.sv
// bf16 product accumulator: sums a burst of bf16 products into an FP32 total
// and emits one result per burst. The FP32 adder rounds to nearest even and flushes subnormals to zero.
module bf16_dot_acc #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [15:0]      i_p,
    input  logic             i_last,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [31:0]      o_sum,
    output logic [CNT_W-1:0] o_count
);

    typedef enum logic {ACC, DONE} state_e;

    function automatic logic [31:0] fp32_add(input logic [31:0] a,
                                             input logic [31:0] b);
        logic              sa, sb, sx, sub;
        logic [7:0]        ea, eb, ex, ey, d8;
        logic [22:0]       ma, mb;
        logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic              swap;
        logic [26:0]       mx, my, mys;
        logic [4:0]        dsh;
        logic [53:0]       sh;
        logic [27:0]       sum;
        logic [26:0]       n;
        logic [4:0]        lz;
        logic              found;
        logic signed [9:0] e;
        logic              rinc;
        logic [24:0]       mr;
        logic [22:0]       man;
        logic [31:0]       r;

        sa = a[31];
        ea = a[30:23];
        ma = a[22:0];
        sb = b[31];
        eb = b[30:23];
        mb = b[22:0];
        a_nan  = (ea == 8'hFF) && (ma != 23'd0);
        b_nan  = (eb == 8'hFF) && (mb != 23'd0);
        a_inf  = (ea == 8'hFF) && (ma == 23'd0);
        b_inf  = (eb == 8'hFF) && (mb == 23'd0);
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);

        swap  = {eb, mb} > {ea, ma};
        sx    = swap ? sb : sa;
        ex    = swap ? eb : ea;
        ey    = swap ? ea : eb;
        mx    = swap ? {1'b1, mb, 3'b000} : {1'b1, ma, 3'b000};
        my    = swap ? {1'b1, ma, 3'b000} : {1'b1, mb, 3'b000};
        sub   = sa ^ sb;
        d8    = ex - ey;
        dsh   = (d8 > 8'd27) ? 5'd27 : d8[4:0];
        // shifted-out bits collapse into the sticky position
        sh    = {my, 27'd0} >> dsh;
        mys   = sh[53:27] | {26'd0, |sh[26:0]};
        sum   = sub ? ({1'b0, mx} - {1'b0, mys})
                    : ({1'b0, mx} + {1'b0, mys});

        lz    = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && sum[i]) begin
                found = 1'b1;
                lz    = 5'(26 - i);
            end
        end

        if (sum[27]) begin
            n = sum[27:1] | {26'd0, sum[0]};
            e = $signed({2'b00, ex}) + 10'sd1;
        end else begin
            n = sum[26:0] << lz;
            e = $signed({2'b00, ex}) - $signed({5'd0, lz});
        end

        rinc = n[2] & (n[1] | n[0] | n[3]);
        mr   = {1'b0, n[26:3]} + {24'd0, rinc};
        man  = mr[22:0];
        if (mr[24]) begin
            e   = e + 10'sd1;
            man = 23'd0;
        end

        if (e >= 10'sd255) begin
            r = {sx, 8'hFF, 23'd0};
        end else if (e <= 10'sd0) begin
            r = {sx, 31'd0};
        end else begin
            r = {sx, e[7:0], man};
        end

        if (a_nan || b_nan || (a_inf && b_inf && sub)) begin
            r = 32'h7FC0_0000;
        end else if (a_inf) begin
            r = {sa, 8'hFF, 23'd0};
        end else if (b_inf) begin
            r = {sb, 8'hFF, 23'd0};
        end else if (a_zero && b_zero) begin
            r = {sa & sb, 31'd0};
        end else if (a_zero) begin
            r = b;
        end else if (b_zero) begin
            r = a;
        end else if (sum == 28'd0) begin
            r = 32'h0000_0000;
        end
        return r;
    endfunction

    state_e            state_q, state_d;
    logic [31:0]       acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       sum_q, sum_d;
    logic [CNT_W-1:0]  ocnt_q, ocnt_d;
    logic [31:0]       add_res;
    logic [CNT_W-1:0]  cnt_inc;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        ocnt_d  = ocnt_q;
        add_res = fp32_add(acc_q, {i_p, 16'h0000});
        cnt_inc = (&cnt_q) ? cnt_q
                           : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        unique case (state_q)
            ACC: begin
                if (i_valid) begin
                    acc_d = add_res;
                    cnt_d = cnt_inc;
                    if (i_last) begin
                        sum_d   = add_res;
                        ocnt_d  = cnt_inc;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (o_ready) begin
                    acc_d   = 32'h0000_0000;
                    cnt_d   = '0;
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ACC;
            acc_q   <= 32'h0000_0000;
            cnt_q   <= '0;
            sum_q   <= 32'h0000_0000;
            ocnt_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            ocnt_q  <= ocnt_d;
        end
    end

    assign i_ready = (state_q == ACC);
    assign o_valid = (state_q == DONE);
    assign o_sum   = sum_q;
    assign o_count = ocnt_q;

endmodule
